register_file: RTL
==================

Name: register_file

Overview:
- Parametrised multi-port register bank that succeeds the single bus register. Holds NUM_REGS general-purpose registers of DATA_WIDTH bits.
- Provides two read ports and one write port, with optional write-to-read bypass and optional registered reads.
- Supports an R0 "base-address" mode: R0 reads as zero while ba_out is asserted.
- Sits in the CPU datapath between the bus/ALU result path and the operand selection logic.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- NUM_REGS, 16, number of registers; must be a power of two, 2..64.
- ADDR_WIDTH, $clog2(NUM_REGS), width of all address ports.
- INIT, 0, value loaded into every register on reset.
- READ_LATENCY, 0, 0 = combinational read; 1 = read data registered, valid one cycle after address.
- BYPASS, 1, 1 = a write to the address being read is forwarded to that read port.
- R0_BA_MODE, 1, 1 = R0 reads as zero on any port while ba_out=1.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- write_enable  in  1  write strobe, sampled on rising clock.
- write_addr  in  ADDR_WIDTH  destination register.
- write_data  in  DATA_WIDTH  data to write.
- read_addr_a  in  ADDR_WIDTH  port A source register.
- read_addr_b  in  ADDR_WIDTH  port B source register.
- ba_out  in  1  R0 zero-force (effective only if R0_BA_MODE=1).
- read_data_a  out  DATA_WIDTH  port A data.
- read_data_b  out  DATA_WIDTH  port B data.

Behaviour:
- Reset:
  - clear=1 immediately sets all registers to INIT, regardless of clock.
  - When READ_LATENCY=1, clear also forces both read output registers to INIT.
  - While clear=1, writes are ignored.
  - Deasserting clear mid-operation leaves the block ready on the next rising edge; nothing is held over.
- Write:
  - On a rising edge with write_enable=1 and clear=0, reg[write_addr] <= write_data.
  - R0 is writable; ba_out does not affect stored contents.
- Read, READ_LATENCY=0:
  - read_data_x = reg[read_addr_x], combinational.
  - With BYPASS=1, write_enable=1 and write_addr==read_addr_x, read_data_x = write_data in the same cycle.
  - With BYPASS=0, the new value is visible only after the edge.
- Read, READ_LATENCY=1:
  - read_data_x is registered from the address sampled at edge N and is valid after edge N.
  - With BYPASS=1, a write to the same address at the same edge returns the new write_data.
  - With BYPASS=0, it returns the pre-write value.
- R0 force:
  - If R0_BA_MODE=1, ba_out=1 and read_addr_x==0, the port returns 0.
  - The force takes priority over bypass.
  - With READ_LATENCY=1, ba_out is sampled with the address at the same edge.
- Simultaneous events:
  - Both ports may read the same address; both return the identical value.
  - Simultaneous write and read of different addresses never interact.
- Out-of-range addresses cannot occur, because NUM_REGS is a power of two.
- Width rule: no truncation or extension internally; all data paths are DATA_WIDTH.

Decomposition:
- Shared package: DATA_WIDTH default, default NUM_REGS, R0 index constant (0), and a regfile_addr_t typedef derived from ADDR_WIDTH.
- One natural sub-module, regfile_read_port. It contains the mux, bypass compare, R0 force and optional output register, and is instantiated twice.
- Storage stays in the top module as a clear-able register array.

Test Plan:
- Reset: drive clear=1 mid-cycle with INIT=32'h0 after writing R5=32'hDEADBEEF -> read_data_a for R5 is 0 immediately, without waiting for a clock edge.
- Basic write/read: write R3=32'h12345678 and R7=32'hCAFEF00D, then read A=R3, B=R7 -> A=32'h12345678, B=32'hCAFEF00D (same cycle for latency 0, one cycle later for latency 1).
- Bypass: same-cycle write R4=32'hA5A5A5A5 with read_addr_a=4 -> BYPASS=1 returns 32'hA5A5A5A5; BYPASS=0 returns the old value (0 after reset).
- R0 force: write R0=32'h00000055, then ba_out=1 with read A=R0 -> 0; ba_out=0 -> 32'h00000055; R0_BA_MODE=0 with ba_out=1 -> 32'h00000055.
- Force over bypass: write R0=32'h11111111 while ba_out=1 and read_addr_a=0 -> A=0; next cycle with ba_out=0 -> 32'h11111111.
- Parametrisation sweep: DATA_WIDTH=16, NUM_REGS=8, READ_LATENCY=1 -> write every register with its index times 16'h0101, read both ports exhaustively -> every value matches with one-cycle latency.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared defaults and types for the register_file slice.
package register_file_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 16;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_NUM_REGS);
  localparam int R0_IDX             = 0;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] regfile_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: storage mux, write bypass, R0 zero-force and optional output register.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int                    NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int                    ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] INIT         = '0,
  parameter int                    READ_LATENCY = 0,
  parameter bit                    BYPASS       = 1'b1,
  parameter bit                    R0_BA_MODE   = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  ba_out,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] rdata_d;

  // Force beats bypass, bypass beats stored value; a write under clear never lands, so it is not forwarded.
  always_comb begin
    rdata_d = regs[read_addr];
    if (BYPASS && write_enable && !clear && (write_addr == read_addr)) begin
      rdata_d = write_data;
    end else begin
      rdata_d = regs[read_addr];
    end
    if (R0_BA_MODE && ba_out && (read_addr == ADDR_WIDTH'(R0_IDX))) begin
      rdata_d = {DATA_WIDTH{1'b0}};
    end else begin
      rdata_d = rdata_d;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
          rdata_q <= INIT;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign read_data = rdata_q;
    end else begin : g_comb
      logic unused_clock;
      assign unused_clock = clock;
      assign read_data    = rdata_d;
    end
  endgenerate

endmodule

// File: rtl/register_file.sv
// Multi-port register bank: clear-able storage array with two read ports and one write port.
module register_file
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int                    NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int                    ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0] INIT         = '0,
  parameter int                    READ_LATENCY = 0,
  parameter bit                    BYPASS       = 1'b1,
  parameter bit                    R0_BA_MODE   = 1'b1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic                  ba_out,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_enable) begin
      regs_d[write_addr] = write_data;
    end else begin
      regs_d[write_addr] = regs_q[write_addr];
    end
  end

  // Clear is asynchronous and dominates any write presented at the same edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= INIT;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INIT        (INIT),
    .READ_LATENCY(READ_LATENCY),
    .BYPASS      (BYPASS),
    .R0_BA_MODE  (R0_BA_MODE)
  ) u_port_a (
    .clock       (clock),
    .clear       (clear),
    .regs        (regs_q),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr   (read_addr_a),
    .ba_out      (ba_out),
    .read_data   (read_data_a)
  );

  regfile_read_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INIT        (INIT),
    .READ_LATENCY(READ_LATENCY),
    .BYPASS      (BYPASS),
    .R0_BA_MODE  (R0_BA_MODE)
  ) u_port_b (
    .clock       (clock),
    .clear       (clear),
    .regs        (regs_q),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr   (read_addr_b),
    .ba_out      (ba_out),
    .read_data   (read_data_b)
  );

endmodule
